fetch_stage: RTL and testbench
==============================

// Module: fetch_stage
// PURPOSE
//  Instruction-fetch stage of the RV32I core. Owns the program counter, drives the byte
//  address into the combinational instruction memory, and captures {pc, pc+4, instr} into
//  the IF/ID pipeline register. Handles decode-stage stall, branch redirect, flush, and a
//  halt state entered on an all-zero (unprogrammed) instruction word.
// PARAMETERS
//  WIDTH     32            datapath / address width
//  RESET_PC  32'h00000000  PC value loaded on reset
//  MEM_BYTES 1028          highest legal fetch byte address + 1; fetching beyond it halts
// PORTS
//  clk            in   1      rising-edge clock
//  rst            in   1      synchronous, active-high reset
//  stall          in   1      hazard unit: hold PC and IF/ID contents
//  flush          in   1      kill the instruction entering IF/ID (insert NOP)
//  branch_taken   in   1      redirect from ID/EX: load branch_target into PC
//  branch_target  in   WIDTH  redirect byte address (bits[1:0] ignored, forced 0)
//  imem_addr      out  WIDTH  byte address to instruction memory (= pc, combinational)
//  imem_data      in   WIDTH  instruction word returned in the same cycle
//  if_id_pc       out  WIDTH  PC of the instruction held in IF/ID
//  if_id_pc4      out  WIDTH  if_id_pc + 4
//  if_id_instr    out  WIDTH  instruction held in IF/ID
//  if_id_valid    out  1      IF/ID holds a real instruction
//  halted         out  1      fetch stage is in HALT
// BEHAVIOUR
//  - Reset (sync, rst=1 at posedge): pc<=RESET_PC, state<=RUN, if_id_pc<=0, if_id_pc4<=4,
//    if_id_instr<=NOP (32'h00000013), if_id_valid<=0, halted<=0. rst mid-operation
//    overrides every other input that cycle.
//  - imem_addr = pc, purely combinational; one instruction per cycle, 1-cycle fetch latency
//    (word fetched at pc appears on if_id_* after the next posedge).
//  - States: RUN, HALT (halted = state==HALT, registered).
//  - Per-edge priority (rst excluded): branch_taken > stall > halt-detect > normal advance.
//    branch_taken: pc<=branch_target&~3; IF/ID <= NOP, valid=0; state<=RUN (exits HALT).
//      Redirect wins over stall in the same cycle.
//    stall (no redirect): pc and all IF/ID fields hold; flush ignored while stalled.
//    RUN, halt-detect: imem_data==32'h0 or pc>=MEM_BYTES -> state<=HALT, pc holds,
//      IF/ID <= NOP, valid=0.
//    RUN normal: pc<=pc+4 (mod 2^WIDTH, wraps silently); if_id_pc<=pc, if_id_pc4<=pc+4,
//      if_id_instr<=imem_data, if_id_valid<=1; if flush=1, instr<=NOP, valid<=0 (pc still advances).
//    HALT, no redirect: pc holds, IF/ID <= NOP, valid=0; flush/stall have no visible effect.
//  - pc+4 uses a WIDTH-bit adder, carry discarded. pc is always word-aligned.
//  - Simultaneous flush+branch_taken: same as branch_taken alone.
// STRUCTURE
//  - Shared package riscv_pkg: NOP_INSTR=32'h00000013, RESET_PC default, fetch state enum
//    {FS_RUN, FS_HALT}.
//  - One sub-module: pc_next_sel (combinational next-PC mux + adder, priority as above);
//    pipeline register and state flop stay in fetch_stage.
// TESTING
//  - Reset: hold rst 2 cycles -> imem_addr=0, if_id_valid=0, if_id_instr=32'h13, halted=0.
//  - Straight line: mem[0]=32'h0000AA03, mem[4]=32'h01400AB3 -> after edge 1 if_id_pc=0,
//    instr=32'h0000AA03; after edge 2 if_id_pc=4, pc4=8, instr=32'h01400AB3; imem_addr=8.
//  - Stall at pc=8 for 3 cycles -> imem_addr stays 8, IF/ID fields unchanged; release -> pc=12.
//  - Redirect: pc=16, branch_taken=1, target=32'h0000000E, stall=1 -> next pc=12, valid=0,
//    instr=NOP; following edge if_id_pc=12.
//  - Halt: imem_data=0 at pc=20 -> halted=1, imem_addr stays 20 for 5 cycles, valid=0;
//    then branch_taken target=0 -> halted=0, pc=0.
//  - Flush at pc=4 (no stall) -> if_id_valid=0, instr=NOP, imem_addr=8; rst asserted in
//    HALT -> next edge pc=0, halted=0.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RV32I core definitions: instruction constants, reset vector and the
// fetch-stage state and next-PC action encodings.
package riscv_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
    localparam logic [31:0] RESET_PC  = 32'h0000_0000;

    typedef enum logic {
        FS_RUN  = 1'b0,
        FS_HALT = 1'b1
    } fetch_state_t;

    // What the fetch stage does on the coming edge, resolved in priority order.
    typedef enum logic [1:0] {
        ACT_ADVANCE  = 2'd0,
        ACT_HOLD     = 2'd1,
        ACT_REDIRECT = 2'd2,
        ACT_HALT     = 2'd3
    } fetch_act_t;

endpackage

// File: rtl/pc_next_sel.sv
// Next-PC selection: resolves redirect / stall / halt / advance priority and
// produces the next PC together with the action the pipeline register applies.
module pc_next_sel
    import riscv_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int MEM_BYTES = 1028
) (
    input  logic [WIDTH-1:0] i_pc,
    input  logic             i_in_halt,
    input  logic             i_stall,
    input  logic             i_branch_taken,
    input  logic [WIDTH-1:0] i_branch_target,
    input  logic [WIDTH-1:0] i_imem_data,
    output logic [WIDTH-1:0] o_pc_next,
    output logic [WIDTH-1:0] o_pc_plus4,
    output fetch_act_t       o_action
);

    logic w_halt_detect;

    // Carry out of the adder is dropped, so the PC wraps silently.
    assign o_pc_plus4    = i_pc + WIDTH'(4);
    assign w_halt_detect = (i_imem_data == '0) || (i_pc >= WIDTH'(MEM_BYTES));

    always_comb begin
        o_pc_next = i_pc;
        o_action  = ACT_HOLD;
        if (i_branch_taken) begin
            o_pc_next = {i_branch_target[WIDTH-1:2], 2'b00};
            o_action  = ACT_REDIRECT;
        end else if (i_in_halt) begin
            // Parked: stall and flush are invisible because IF/ID is already a bubble.
            o_action = ACT_HALT;
        end else if (i_stall) begin
            o_action = ACT_HOLD;
        end else if (w_halt_detect) begin
            o_action = ACT_HALT;
        end else begin
            o_pc_next = o_pc_plus4;
            o_action  = ACT_ADVANCE;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// RV32I instruction-fetch stage: owns the PC, addresses the combinational
// instruction memory and fills the IF/ID pipeline register.
module fetch_stage
    import riscv_pkg::*;
#(
    parameter int          WIDTH     = 32,
    parameter logic [31:0] RESET_PC  = riscv_pkg::RESET_PC,
    parameter int          MEM_BYTES = 1028
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             flush,
    input  logic             branch_taken,
    input  logic [WIDTH-1:0] branch_target,
    output logic [WIDTH-1:0] imem_addr,
    input  logic [WIDTH-1:0] imem_data,
    output logic [WIDTH-1:0] if_id_pc,
    output logic [WIDTH-1:0] if_id_pc4,
    output logic [WIDTH-1:0] if_id_instr,
    output logic             if_id_valid,
    output logic             halted
);

    fetch_state_t     r_state, w_state_next;
    logic [WIDTH-1:0] r_pc;
    logic [WIDTH-1:0] r_if_id_pc, r_if_id_pc4, r_if_id_instr;
    logic             r_if_id_valid;

    logic [WIDTH-1:0] w_pc_next, w_pc_plus4;
    logic [WIDTH-1:0] w_if_id_pc_next, w_if_id_pc4_next, w_if_id_instr_next;
    logic             w_if_id_valid_next;
    fetch_act_t       w_action;

    pc_next_sel #(
        .WIDTH     (WIDTH),
        .MEM_BYTES (MEM_BYTES)
    ) u_pc_next_sel (
        .i_pc            (r_pc),
        .i_in_halt       (r_state == FS_HALT),
        .i_stall         (stall),
        .i_branch_taken  (branch_taken),
        .i_branch_target (branch_target),
        .i_imem_data     (imem_data),
        .o_pc_next       (w_pc_next),
        .o_pc_plus4      (w_pc_plus4),
        .o_action        (w_action)
    );

    always_ff @(posedge clk) begin
        if (rst) r_state <= FS_RUN;
        else     r_state <= w_state_next;
    end

    always_comb begin
        w_state_next       = r_state;
        w_if_id_pc_next    = r_if_id_pc;
        w_if_id_pc4_next   = r_if_id_pc4;
        w_if_id_instr_next = r_if_id_instr;
        w_if_id_valid_next = r_if_id_valid;
        unique case (w_action)
            ACT_REDIRECT: begin
                w_state_next       = FS_RUN;
                w_if_id_instr_next = WIDTH'(NOP_INSTR);
                w_if_id_valid_next = 1'b0;
            end
            ACT_HALT: begin
                w_state_next       = FS_HALT;
                w_if_id_instr_next = WIDTH'(NOP_INSTR);
                w_if_id_valid_next = 1'b0;
            end
            ACT_ADVANCE: begin
                w_if_id_pc_next    = r_pc;
                w_if_id_pc4_next   = w_pc_plus4;
                w_if_id_instr_next = flush ? WIDTH'(NOP_INSTR) : imem_data;
                w_if_id_valid_next = ~flush;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc          <= WIDTH'(RESET_PC);
            r_if_id_pc    <= '0;
            r_if_id_pc4   <= WIDTH'(4);
            r_if_id_instr <= WIDTH'(NOP_INSTR);
            r_if_id_valid <= 1'b0;
        end else begin
            r_pc          <= w_pc_next;
            r_if_id_pc    <= w_if_id_pc_next;
            r_if_id_pc4   <= w_if_id_pc4_next;
            r_if_id_instr <= w_if_id_instr_next;
            r_if_id_valid <= w_if_id_valid_next;
        end
    end

    assign imem_addr   = r_pc;
    assign if_id_pc    = r_if_id_pc;
    assign if_id_pc4   = r_if_id_pc4;
    assign if_id_instr = r_if_id_instr;
    assign if_id_valid = r_if_id_valid;
    assign halted      = (r_state == FS_HALT);

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: a small word-array instruction memory and
// hand-computed expectations for reset, advance, stall, redirect, halt and flush.
module tb_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst, stall, flush, branch_taken;
    logic [31:0] branch_target, imem_addr, imem_data;
    logic [31:0] if_id_pc, if_id_pc4, if_id_instr;
    logic        if_id_valid, halted;

    logic [31:0] mem [0:511];
    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    assign imem_data = (imem_addr < 32'd2048) ? mem[imem_addr[10:2]] : 32'h0;

    fetch_stage #(.WIDTH(32), .RESET_PC(32'h0), .MEM_BYTES(1028)) dut (
        .clk           (clk),
        .rst           (rst),
        .stall         (stall),
        .flush         (flush),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .imem_addr     (imem_addr),
        .imem_data     (imem_data),
        .if_id_pc      (if_id_pc),
        .if_id_pc4     (if_id_pc4),
        .if_id_instr   (if_id_instr),
        .if_id_valid   (if_id_valid),
        .halted        (halted)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end else begin
            $display("ok   %s = %h", tag, got);
        end
    endtask

    // Advance one edge; inputs change and outputs are sampled 1ns after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 512; i++) mem[i] = NOP;
        mem[0] = 32'h0000_AA03;
        mem[1] = 32'h0140_0AB3;
        mem[2] = 32'h0010_0093;
        mem[3] = 32'h0020_0113;
        mem[4] = 32'h0030_0193;
        mem[5] = 32'h0000_0000;

        rst = 1'b1; stall = 1'b0; flush = 1'b0; branch_taken = 1'b0; branch_target = '0;
        tick(); tick();
        chk("rst_addr",  imem_addr, 32'h0);
        chk("rst_valid", {31'b0, if_id_valid}, 32'h0);
        chk("rst_instr", if_id_instr, NOP);
        chk("rst_halt",  {31'b0, halted}, 32'h0);
        chk("rst_pc4",   if_id_pc4, 32'h4);

        rst = 1'b0;
        tick();
        chk("e1_pc",    if_id_pc, 32'h0);
        chk("e1_instr", if_id_instr, 32'h0000_AA03);
        chk("e1_valid", {31'b0, if_id_valid}, 32'h1);
        tick();
        chk("e2_pc",    if_id_pc, 32'h4);
        chk("e2_pc4",   if_id_pc4, 32'h8);
        chk("e2_instr", if_id_instr, 32'h0140_0AB3);
        chk("e2_addr",  imem_addr, 32'h8);

        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            flush = (i == 1);
            tick();
            chk("stall_addr",  imem_addr, 32'h8);
            chk("stall_pc",    if_id_pc, 32'h4);
            chk("stall_instr", if_id_instr, 32'h0140_0AB3);
            chk("stall_valid", {31'b0, if_id_valid}, 32'h1);
        end
        stall = 1'b0; flush = 1'b0;
        tick();
        chk("rel_addr",  imem_addr, 32'hC);
        chk("rel_pc",    if_id_pc, 32'h8);
        chk("rel_instr", if_id_instr, 32'h0010_0093);
        tick();
        chk("pc16_addr", imem_addr, 32'h10);

        branch_taken = 1'b1; branch_target = 32'h0000_000E; stall = 1'b1; flush = 1'b1;
        tick();
        chk("br_addr",  imem_addr, 32'hC);
        chk("br_valid", {31'b0, if_id_valid}, 32'h0);
        chk("br_instr", if_id_instr, NOP);
        branch_taken = 1'b0; stall = 1'b0; flush = 1'b0;
        tick();
        chk("br2_pc",    if_id_pc, 32'hC);
        chk("br2_instr", if_id_instr, 32'h0020_0113);
        chk("br2_valid", {31'b0, if_id_valid}, 32'h1);
        tick();
        chk("pc20_addr", imem_addr, 32'h14);

        for (int i = 0; i < 5; i++) begin
            stall = i[0]; flush = i[1];
            tick();
            chk("halt_flag",  {31'b0, halted}, 32'h1);
            chk("halt_addr",  imem_addr, 32'h14);
            chk("halt_valid", {31'b0, if_id_valid}, 32'h0);
            chk("halt_instr", if_id_instr, NOP);
        end
        stall = 1'b0; flush = 1'b0;
        branch_taken = 1'b1; branch_target = 32'h0;
        tick();
        chk("unhalt_flag", {31'b0, halted}, 32'h0);
        chk("unhalt_addr", imem_addr, 32'h0);
        branch_taken = 1'b0;
        tick();
        chk("re_instr", if_id_instr, 32'h0000_AA03);
        chk("re_addr",  imem_addr, 32'h4);

        flush = 1'b1;
        tick();
        chk("fl_valid", {31'b0, if_id_valid}, 32'h0);
        chk("fl_instr", if_id_instr, NOP);
        chk("fl_addr",  imem_addr, 32'h8);
        chk("fl_pc",    if_id_pc, 32'h4);
        flush = 1'b0;

        branch_taken = 1'b1; branch_target = 32'h0000_0400;
        tick();
        branch_taken = 1'b0;
        tick();
        chk("lim_pc",    if_id_pc, 32'h400);
        chk("lim_valid", {31'b0, if_id_valid}, 32'h1);
        chk("lim_addr",  imem_addr, 32'h404);
        tick();
        chk("oob_flag", {31'b0, halted}, 32'h1);
        chk("oob_addr", imem_addr, 32'h404);

        rst = 1'b1;
        tick();
        chk("rsth_addr",  imem_addr, 32'h0);
        chk("rsth_flag",  {31'b0, halted}, 32'h0);
        chk("rsth_valid", {31'b0, if_id_valid}, 32'h0);
        rst = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
